// File: rtl/universal_gate_unit.sv
// rtl/universal_gate_unit.sv - bitwise gate unit with a 2-entry in-order result buffer
module universal_gate_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;
    logic             started;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = ~(a & b);
            3'b001:  result = ~(a | b);
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = ~(a ^ b);
            3'b110:  result = ~a;
            default: result = a;
        endcase
    end

    // started keeps in_ready low until the first edge after reset release
    assign in_ready  = started && (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign y      = out_valid ? mem[rd_ptr] : '0;
    assign y_zero = out_valid && (y == '0);
    assign y_ones = out_valid && (&y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            started  <= 1'b0;
            op_count <= '0;
        end else begin
            started <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (op_count != {CNT_W{1'b1}})
                    op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_gate_unit.sv
// tb/tb_universal_gate_unit.sv - queue-model checked directed bench for universal_gate_unit
module tb_universal_gate_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;

    logic       in_ready, out_valid, y_zero, y_ones;
    logic [3:0] y;
    logic [7:0] op_count;

    logic       in_ready2, out_valid2, y_zero2, y_ones2;
    logic [3:0] y2;
    logic [1:0] op_count2;

    int tests = 0;
    int fails = 0;

    universal_gate_unit #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_zero(y_zero), .y_ones(y_ones), .op_count(op_count)
    );

    universal_gate_unit #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .y_zero(y_zero2), .y_ones(y_ones2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gate(input logic [3:0] x, input logic [3:0] w, input logic [2:0] o);
        logic [3:0] r;
        case (o)
            3'd0: r = ~(x & w);
            3'd1: r = ~(x | w);
            3'd2: r = x & w;
            3'd3: r = x | w;
            3'd4: r = x ^ w;
            3'd5: r = ~(x ^ w);
            3'd6: r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    // Model: ordered queue of pending results, delivered counters, ready-enable flag
    logic [3:0] mq[$];
    int  mc1, mc2;
    bit  men, m_push, m_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mc1 = 0;
            mc2 = 0;
            men = 0;
        end else begin
            m_push = in_valid && men && (mq.size() < 2);
            m_pop  = out_ready && (mq.size() > 0);
            if (m_pop) begin
                void'(mq.pop_front());
                if (mc1 < 255) mc1++;
                if (mc2 < 3) mc2++;
            end
            if (m_push) mq.push_back(gate(a, b, op));
            men = 1;
        end
    end

    always @(negedge clk) begin
        bit         ev;
        logic [3:0] ey;
        ev = (mq.size() > 0);
        ey = ev ? mq[0] : 4'd0;
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, men && (mq.size() < 2));
        chk("y", y, ey);
        chk("y_zero", y_zero, ev && (ey == 4'd0));
        chk("y_ones", y_ones, ev && (ey == 4'hf));
        chk("op_count", op_count, mc1);
        chk("op_count_cnt2", op_count2, mc2);
        chk("out_valid_cnt2", out_valid2, ev);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] lit30 [8] = '{4'b1110, 4'b1000, 4'b0001, 4'b0111, 4'b0110, 4'b1001, 4'b1100, 4'b0011};
    logic [1:0] lit34 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) cyc();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_op_count", op_count, 8'd0);
        rst = 1'b0;
        cyc();
        chk("ready_after_release", in_ready, 1'b1);

        // saturating counter on the CNT_W=2 instance
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5); a = 4'(i); b = 4'd0; op = 3'd7;
            cyc();
            if (i >= 1) chk("sat_seq", op_count2, lit34[i-1]);
        end
        in_valid = 1'b0;

        rst = 1'b1; cyc(); rst = 1'b0; cyc();

        // all ops on a=0011 b=0101, one result per cycle
        for (int i = 0; i < 8; i++) begin
            chk("model_gate", gate(4'b0011, 4'b0101, 3'(i)), lit30[i]);
            in_valid = 1'b1; a = 4'b0011; b = 4'b0101; op = 3'(i);
            cyc();
            chk("op_table_y", y, lit30[i]);
        end
        in_valid = 1'b0;
        cyc();
        chk("op_table_count", op_count, 8'd8);

        // back-pressure: only two accepted, head held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 4'(i + 1); b = 4'd0; op = 3'd3;
            cyc();
            chk("bp_y_held", y, 4'd1);
            chk("bp_in_ready", in_ready, (i == 0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bp_second", y, 4'd2);
        cyc();
        chk("bp_drained", out_valid, 1'b0);
        chk("bp_ready_back", in_ready, 1'b1);

        // simultaneous push and pop at occupancy 1
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd5; op = 3'd7;
        cyc();
        out_ready = 1'b1; a = 4'd9;
        cyc();
        chk("pp_head", y, 4'd9);
        chk("pp_count", op_count, 8'd11);
        in_valid = 1'b0;
        cyc();

        // flag corners
        in_valid = 1'b1; a = 4'hf; b = 4'hf; op = 3'd2;
        cyc();
        chk("ones_y", y, 4'hf);
        chk("ones_flag", y_ones, 1'b1);
        a = 4'h0; b = 4'h0; op = 3'd3;
        cyc();
        chk("zero_y", y, 4'h0);
        chk("zero_flag", y_zero, 1'b1);
        in_valid = 1'b0;
        cyc();

        // asynchronous reset with a full buffer
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd6; op = 3'd7;
        cyc(); cyc();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_y", y, 4'd0);
        chk("arst_op_count", op_count, 8'd0);
        chk("arst_in_ready", in_ready, 1'b0);
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready_first_edge", in_ready, 1'b1);
        chk("arst_no_stale", out_valid, 1'b0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
